// File: rtl/ex_stage_mc.sv
// Execute stage: ID/EX operand capture, single-cycle ALU and an iterative RV32M
// multiply/divide unit, with valid/ready handshakes, flush and back-pressure.
// Emits the register write-back triple (out_we, out_waddr, out_wdata).
module ex_stage_mc #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_waddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [REG_AW-1:0] out_waddr,
    output logic [XLEN-1:0]   out_wdata,
    output logic              busy
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    // opd_q: multiplicand or divisor magnitude
    // hi_q:  product high half or partial remainder
    // lo_q:  multiplier / product low half, or dividend / quotient
    logic [XLEN-1:0]   opd_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    // op_q[2]: divide, op_q[1]: remainder (divide), op_q[0]: high half (multiply)
    logic [2:0]        op_q;
    logic              we_q;
    logic [REG_AW-1:0] waddr_q;
    logic              quo_neg_q;
    logic              rem_neg_q;

    logic              accept;
    logic              is_m;
    logic              is_div;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   m_res;
    logic              m_done;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;

    assign busy     = (state_q != StIdle);
    assign in_ready = rdy & ~flush & (state_q == StIdle) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign is_m     = in_op[3] & (in_op[2] | in_op[1]);
    assign is_div   = in_op[3] & in_op[2];
    assign m_done   = (state_q != StIdle) && (cnt_q == '0);

    // Signed divide works on magnitudes; signs are reapplied at completion.
    assign a_neg = is_div & ~in_op[0] & in_a[XLEN-1];
    assign b_neg = is_div & ~in_op[0] & in_b[XLEN-1];
    assign a_mag = a_neg ? (XLEN'(0) - in_a) : in_a;
    assign b_mag = b_neg ? (XLEN'(0) - in_b) : in_b;

    // One shift-add multiply step and one restoring-divide step.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = (div_sh >= {1'b0, opd_q});
    assign div_diff = div_sh[XLEN-1:0] - opd_q;

    // Single-cycle ALU on the incoming operands.
    always_comb begin
        alu_res = '0;
        case (in_op)
            4'd0:    alu_res = in_a + in_b;
            4'd1:    alu_res = in_a - in_b;
            4'd2:    alu_res = in_a & in_b;
            4'd3:    alu_res = in_a | in_b;
            4'd4:    alu_res = in_a ^ in_b;
            4'd5:    alu_res = in_a << in_b[SHW-1:0];
            4'd6:    alu_res = in_a >> in_b[SHW-1:0];
            4'd7:    alu_res = $unsigned($signed(in_a) >>> in_b[SHW-1:0]);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            default: alu_res = '0;
        endcase
    end

    // Final multiply/divide result selection with sign fix-up.
    always_comb begin
        m_res = '0;
        if (!op_q[2]) begin
            m_res = op_q[0] ? hi_q : lo_q;
        end else if (op_q[1]) begin
            m_res = rem_neg_q ? (XLEN'(0) - hi_q) : hi_q;
        end else begin
            m_res = quo_neg_q ? (XLEN'(0) - lo_q) : lo_q;
        end
    end

    // Stage state: output slot, iteration FSM and operand registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_q      <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            out_waddr <= '0;
            out_wdata <= '0;
        end else if (rdy) begin
            if (flush) begin
                // Kill the output and any iteration; a completing result is dropped.
                out_valid <= 1'b0;
                out_we    <= 1'b0;
                state_q   <= StIdle;
                cnt_q     <= '0;
            end else begin
                if (accept && !is_m) begin
                    out_valid <= 1'b1;
                    out_we    <= in_we & (|in_waddr);
                    out_waddr <= in_waddr;
                    out_wdata <= alu_res;
                end else if (m_done) begin
                    out_valid <= 1'b1;
                    out_we    <= we_q & (|waddr_q);
                    out_waddr <= waddr_q;
                    out_wdata <= m_res;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    out_we    <= 1'b0;
                end

                case (state_q)
                    StIdle: begin
                        if (accept && is_m) begin
                            state_q <= is_div ? StDiv : StMul;
                            cnt_q   <= CNT_W'(XLEN);
                            op_q    <= in_op[2:0];
                            we_q    <= in_we;
                            waddr_q <= in_waddr;
                            hi_q    <= '0;
                            if (is_div) begin
                                opd_q     <= b_mag;
                                lo_q      <= a_mag;
                                // Divide by zero yields -1 regardless of dividend sign.
                                quo_neg_q <= (a_neg ^ b_neg) & (|in_b);
                                rem_neg_q <= a_neg;
                            end else begin
                                opd_q     <= in_a;
                                lo_q      <= in_b;
                                quo_neg_q <= 1'b0;
                                rem_neg_q <= 1'b0;
                            end
                        end
                    end
                    StMul: begin
                        if (cnt_q != '0) begin
                            hi_q  <= mul_sum[XLEN:1];
                            lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StDiv: begin
                        if (cnt_q != '0) begin
                            hi_q  <= div_ge ? div_diff : div_sh[XLEN-1:0];
                            lo_q  <= {lo_q[XLEN-2:0], div_ge};
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
